// File: rtl/ram_bank.sv
// ram_bank: byte-addressable single-port RAM on the core memory bus.
// A request is captured in IDLE, optionally waits LATENCY cycles in WAIT,
// and completes in DONE with a one-cycle Ack pulse, flagged by Err when the
// captured access was out of range or misaligned.
//
// Handshake: the master raises Cs with Addr/We/Be/Wdata and holds it until
// Ack. The request is captured on the first rising edge in IDLE with Cs=1;
// later input changes are ignored. Ack is high for exactly one cycle (DONE),
// Rdata/Err are valid only while Ack=1, and Cs is ignored during DONE. The
// earliest next acceptance is the edge after DONE.
module ram_bank #(
   parameter int CAPACITY    = 1024,
   parameter int WORD_SIZE   = 4,
   parameter int LATENCY     = 0,
   parameter int ALIGN_CHECK = 1
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic [$clog2(CAPACITY)-1:0]  Addr,
   input  logic                         Cs,
   input  logic                         We,
   input  logic [WORD_SIZE-1:0]         Be,
   input  logic [8*WORD_SIZE-1:0]       Wdata,
   output logic [8*WORD_SIZE-1:0]       Rdata,
   output logic                         Ack,
   output logic                         Err,
   output logic [1:0]                   State_dbg
);

   localparam int AW = $clog2(CAPACITY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;

   logic [AW-1:0]            addr_q;
   logic                     we_q;
   logic [WORD_SIZE-1:0]     be_q;
   logic [8*WORD_SIZE-1:0]   wdata_q;

   // The request in flight: straight from the bus in IDLE (needed when
   // LATENCY=0 completes on the accepting edge), from the capture registers
   // otherwise.
   logic [AW-1:0]            cur_addr;
   logic                     cur_we;
   logic [WORD_SIZE-1:0]     cur_be;
   logic [8*WORD_SIZE-1:0]   cur_wdata;

   logic                     range_err;
   logic                     align_err;
   logic                     req_err;
   logic                     enter_done;
   logic                     wr_commit;
   logic [8*WORD_SIZE-1:0]   rd_word;

   logic [7:0]               mem [CAPACITY];

   assign State_dbg = state_q;

   // Select the live request source and evaluate the error checks on it.
   always_comb begin
      cur_addr  = addr_q;
      cur_we    = we_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
      if (state_q == IDLE) begin
         cur_addr  = Addr;
         cur_we    = We;
         cur_be    = Be;
         cur_wdata = Wdata;
      end
      range_err = (32'(cur_addr) + 32'(WORD_SIZE)) > 32'(CAPACITY);
      align_err = (ALIGN_CHECK != 0) &&
                  ((32'(cur_addr) % 32'(WORD_SIZE)) != 32'd0);
      req_err   = range_err || align_err;
   end

   // Next-state logic: IDLE accepts, WAIT counts down, DONE always returns.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (Cs) begin
               if (LATENCY == 0) begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = DONE;
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the request on the accepting edge so later bus changes are ignored.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (state_q == IDLE && Cs) begin
         addr_q  <= Addr;
         we_q    <= We;
         be_q    <= Be;
         wdata_q <= Wdata;
      end
   end

   // Gather the addressed bytes, little-endian.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < WORD_SIZE; i++) begin
         rd_word[8*i +: 8] = mem[cur_addr + AW'(i)];
      end
   end

   assign wr_commit = Rst_n && enter_done && cur_we && !req_err;

   // Byte-masked write, committed on the edge entering DONE; never reset.
   always_ff @(posedge Clk) begin
      if (wr_commit) begin
         for (int i = 0; i < WORD_SIZE; i++) begin
            if (cur_be[i]) begin
               mem[cur_addr + AW'(i)] <= cur_wdata[8*i +: 8];
            end
         end
      end
   end

   // Completion outputs: registered so they are high only during DONE.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Ack   <= 1'b0;
         Err   <= 1'b0;
         Rdata <= '0;
      end else begin
         Ack   <= enter_done;
         Err   <= enter_done && req_err;
         Rdata <= (enter_done && !cur_we && !req_err) ? rd_word : '0;
      end
   end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: directed checks of ram_bank in three configurations:
//   dut 0: defaults (LATENCY=0, ALIGN_CHECK=1)
//   dut 1: LATENCY=3, ALIGN_CHECK=1
//   dut 2: LATENCY=2, ALIGN_CHECK=0
module tb_ram_bank;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic [9:0]  addr  [3];
  logic        cs    [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic [1:0]  st    [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];

  ram_bank #(.CAPACITY(1024), .WORD_SIZE(4), .LATENCY(0), .ALIGN_CHECK(1)) u_dut0 (
    .Clk(clk), .Rst_n(rst_n[0]), .Addr(addr[0]), .Cs(cs[0]), .We(we[0]),
    .Be(be[0]), .Wdata(wdata[0]), .Rdata(rdata[0]), .Ack(ack[0]), .Err(err[0]),
    .State_dbg(st[0]));

  ram_bank #(.CAPACITY(1024), .WORD_SIZE(4), .LATENCY(3), .ALIGN_CHECK(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n[1]), .Addr(addr[1]), .Cs(cs[1]), .We(we[1]),
    .Be(be[1]), .Wdata(wdata[1]), .Rdata(rdata[1]), .Ack(ack[1]), .Err(err[1]),
    .State_dbg(st[1]));

  ram_bank #(.CAPACITY(1024), .WORD_SIZE(4), .LATENCY(2), .ALIGN_CHECK(0)) u_dut2 (
    .Clk(clk), .Rst_n(rst_n[2]), .Addr(addr[2]), .Cs(cs[2]), .We(we[2]),
    .Be(be[2]), .Wdata(wdata[2]), .Rdata(rdata[2]), .Ack(ack[2]), .Err(err[2]),
    .State_dbg(st[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // driver: one full request, returns edges-to-Ack (accepting edge = 1),
  // the data/err seen with Ack, then checks the cycle after Ack is quiet.
  task automatic access(input int idx, input logic w, input logic [9:0] a,
                        input logic [3:0] b, input logic [31:0] d, input string tag,
                        output int edges, output logic [31:0] rd, output logic er);
    @(negedge clk);
    addr[idx] = a; we[idx] = w; be[idx] = b; wdata[idx] = d; cs[idx] = 1'b1;
    edges = 0; rd = '0; er = 1'b0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (ack[idx]) break;
    end
    if (ack[idx]) begin
      rd = rdata[idx];
      er = err[idx];
    end
    cs[idx] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s_post_ack", tag), 64'(ack[idx]), 64'd0);
    check($sformatf("%s_post_rdata", tag), 64'(rdata[idx]), 64'd0);
  endtask

  task automatic read_check(input int idx, input logic [9:0] a, input logic [31:0] expd,
                            input int exp_edges, input string tag);
    int e; logic [31:0] rd; logic er;
    exp_q.push_back(expd);
    access(idx, 1'b0, a, 4'h0, 32'h0, tag, e, rd, er);
    check($sformatf("%s_edges", tag), 64'(e), 64'(exp_edges));
    check($sformatf("%s_err", tag), 64'(er), 64'd0);
    check($sformatf("%s_rdata", tag), 64'(rd), 64'(exp_q.pop_front()));
  endtask

  task automatic write_ok(input int idx, input logic [9:0] a, input logic [3:0] b,
                          input logic [31:0] d, input int exp_edges, input string tag);
    int e; logic [31:0] rd; logic er;
    access(idx, 1'b1, a, b, d, tag, e, rd, er);
    check($sformatf("%s_edges", tag), 64'(e), 64'(exp_edges));
    check($sformatf("%s_err", tag), 64'(er), 64'd0);
    check($sformatf("%s_rdata", tag), 64'(rd), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int acks;
    logic [31:0] rd;
    logic er;

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; addr[i] = '0; cs[i] = 1'b0; we[i] = 1'b0;
      be[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ack", 64'(ack[0]), 64'd0);
    check("rst_err", 64'(err[0]), 64'd0);
    check("rst_rdata", 64'(rdata[0]), 64'd0);
    check("rst_state", 64'(st[0]), 64'(S_IDLE));
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // defaults: write then read
    write_ok(0, 10'h010, 4'hF, 32'hDEADBEEF, 1, "d0_wr10");
    read_check(0, 10'h010, 32'hDEADBEEF, 1, "d0_rd10");

    // byte enables
    write_ok(0, 10'h010, 4'b0101, 32'h11223344, 1, "d0_wr_be");
    read_check(0, 10'h010, 32'hDE22BE44, 1, "d0_rd_be");

    // Be=0 is a no-op that still acks
    write_ok(0, 10'h010, 4'b0000, 32'hFFFFFFFF, 1, "d0_wr_be0");
    read_check(0, 10'h010, 32'hDE22BE44, 1, "d0_rd_be0");

    // misaligned read is an error
    access(0, 1'b0, 10'h012, 4'h0, 32'h0, "d0_misal", e, rd, er);
    check("d0_misal_edges", 64'(e), 64'd1);
    check("d0_misal_err", 64'(er), 64'd1);
    check("d0_misal_rdata", 64'(rd), 64'd0);

    // range error write leaves memory unchanged
    write_ok(0, 10'h3FC, 4'hF, 32'h00000000, 1, "d0_wr3fc");
    access(0, 1'b1, 10'h3FE, 4'hF, 32'h55667788, "d0_range", e, rd, er);
    check("d0_range_edges", 64'(e), 64'd1);
    check("d0_range_err", 64'(er), 64'd1);
    read_check(0, 10'h3FC, 32'h00000000, 1, "d0_rd3fc");

    // LATENCY=3
    write_ok(1, 10'h040, 4'hF, 32'h01020304, 4, "d1_wr40");
    write_ok(1, 10'h044, 4'hF, 32'hA5A5A5A5, 4, "d1_wr44");
    @(negedge clk);
    addr[1] = 10'h040; we[1] = 1'b0; be[1] = 4'h0; cs[1] = 1'b1;
    @(posedge clk); #1;
    e = 1;
    check("d1_lat_wait_state", 64'(st[1]), 64'(S_WAIT));
    check("d1_lat_wait_ack", 64'(ack[1]), 64'd0);
    addr[1] = 10'h044;
    while (e < 40 && !ack[1]) begin
      @(posedge clk); #1;
      e++;
    end
    check("d1_lat_edges", 64'(e), 64'd4);
    check("d1_lat_rdata", 64'(rdata[1]), 64'h01020304);
    check("d1_lat_done_state", 64'(st[1]), 64'(S_DONE));
    // Cs still high across the DONE edge: must not restart
    @(posedge clk); #1;
    check("d1_hold_state", 64'(st[1]), 64'(S_IDLE));
    check("d1_hold_ack", 64'(ack[1]), 64'd0);
    cs[1] = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    check("d1_hold_extra_acks", 64'(acks), 64'd0);

    // ALIGN_CHECK=0, LATENCY=2: word-crossing read
    write_ok(2, 10'h010, 4'hF, 32'hDEADBEEF, 3, "d2_wr10");
    write_ok(2, 10'h014, 4'hF, 32'h00000000, 3, "d2_wr14");
    read_check(2, 10'h011, 32'h00DEADBE, 3, "d2_rd11");

    // reset while in DONE clears Ack/Rdata without a clock edge
    @(negedge clk);
    addr[2] = 10'h010; we[2] = 1'b0; cs[2] = 1'b1;
    e = 0;
    while (e < 40 && !ack[2]) begin
      @(posedge clk); #1;
      e++;
    end
    check("d2_done_rdata", 64'(rdata[2]), 64'hDEADBEEF);
    cs[2] = 1'b0;
    #1 rst_n[2] = 1'b0;
    #1;
    check("d2_async_ack", 64'(ack[2]), 64'd0);
    check("d2_async_rdata", 64'(rdata[2]), 64'd0);
    check("d2_async_state", 64'(st[2]), 64'(S_IDLE));
    @(negedge clk);
    rst_n[2] = 1'b1;

    // reset during WAIT of a write abandons it
    write_ok(2, 10'h020, 4'hF, 32'h00000000, 3, "d2_wr20");
    @(negedge clk);
    addr[2] = 10'h020; we[2] = 1'b1; be[2] = 4'hF; wdata[2] = 32'hCAFEF00D; cs[2] = 1'b1;
    @(posedge clk); #1;
    check("d2_rstw_wait_state", 64'(st[2]), 64'(S_WAIT));
    #2 rst_n[2] = 1'b0;
    #1;
    check("d2_rstw_state", 64'(st[2]), 64'(S_IDLE));
    check("d2_rstw_ack", 64'(ack[2]), 64'd0);
    check("d2_rstw_err", 64'(err[2]), 64'd0);
    check("d2_rstw_rdata", 64'(rdata[2]), 64'd0);
    cs[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[2]) acks++;
    end
    check("d2_rstw_no_ack", 64'(acks), 64'd0);
    read_check(2, 10'h020, 32'h00000000, 3, "d2_rd20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
